// File: rtl/marker_gen.sv
// Bullseye-row test pattern source: one striped marker on a grey frame.
// Define MARKER_GEN_NOISE_EN to add LFSR single-pixel band glitches.
module marker_gen #(
    parameter int         H_ACTIVE      = 1024,
    parameter int         V_ACTIVE      = 768,
    parameter int         MARKER_ROWS   = 32,
    parameter int         LEFT_STRIPES  = 5,
    parameter int         RIGHT_STRIPES = 4,
    parameter logic [2:0] WHITE_RGB     = 3'b111,
    parameter logic [2:0] BLACK_RGB     = 3'b000,
    parameter logic [2:0] BG_RGB        = 3'b010
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        pixel_en_in,
    input  logic [10:0] centre_x_in,
    input  logic [10:0] centre_y_in,
    input  logic [7:0]  stripe_w_in,
    output logic        busy_out,
    output logic        valid_out,
    output logic [2:0]  rgb_out,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        line_end_out,
    output logic        frame_end_out
);

    localparam int NBANDS = LEFT_STRIPES + RIGHT_STRIPES + 1;
    localparam int HALF   = MARKER_ROWS / 2;

    localparam logic [3:0]  LAST_BAND = 4'(NBANDS - 1);
    localparam logic [3:0]  CTR_BAND  = 4'(LEFT_STRIPES);
    localparam logic [10:0] H_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST    = 11'(V_ACTIVE - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BG_PRE  = 3'd1;
    localparam logic [2:0] S_BAND    = 3'd2;
    localparam logic [2:0] S_BG_POST = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_COOL    = 3'd5;

    function automatic logic f_row_on(
        input logic [10:0] row,
        input logic [10:0] cy
    );
        logic [11:0] r;
        logic [11:0] c;
        r = {1'b0, row};
        c = {1'b0, cy};
        return (r + 12'(HALF) >= c) && (r < c + 12'(MARKER_ROWS - HALF));
    endfunction

    function automatic logic signed [12:0] f_x0(
        input logic [10:0] cx,
        input logic [7:0]  w
    );
        logic [12:0] a;
        a = {2'b00, cx} - 13'(w) * 13'(LEFT_STRIPES + 1);
        return $signed(a);
    endfunction

    // Row-start state; a marker clipped on the left is entered mid-band.
    function automatic logic [15:0] f_entry(
        input logic [10:0]        row,
        input logic [10:0]        cy,
        input logic signed [12:0] x0,
        input logic [7:0]         w
    );
        logic [12:0] n;
        logic [12:0] e;
        logic [3:0]  b;
        logic [8:0]  rem;
        logic [2:0]  st;
        st  = S_BG_PRE;
        b   = 4'd0;
        rem = 9'd0;
        n   = 13'd0 - $unsigned(x0);
        if (f_row_on(row, cy) && !(x0 > 13'sd0)) begin
            st = S_BG_POST;
            for (int k = NBANDS - 1; k >= 0; k--) begin
                e = 13'(w) * 13'((k < LEFT_STRIPES) ? k + 1 : k + 2);
                if (n < e) begin
                    st  = S_BAND;
                    b   = 4'(k);
                    rem = 9'(e - n);
                end
            end
        end
        return {st, b, rem};
    endfunction

    logic [2:0]         r_state;
    logic [3:0]         r_band;
    logic [8:0]         r_cnt;
    logic [10:0]        r_h;
    logic [10:0]        r_v;
    logic [10:0]        r_cy;
    logic [7:0]         r_w;
    logic signed [12:0] r_x0;
    logic               r_busy;
    logic               r_valid;
    logic [2:0]         r_rgb;
    logic [10:0]        r_hcnt;
    logic [10:0]        r_vcnt;
    logic               r_le;
    logic               r_fe;

    logic [7:0]         w_w_in;
    logic signed [12:0] w_x0_in;
    logic [15:0]        w_entry0;
    logic [15:0]        w_entry_nxt;
    logic               w_row_on;
    logic               w_glitch;
    logic [2:0]         w_pix_rgb;
    logic [2:0]         w_nstate;
    logic [3:0]         w_nband;
    logic [8:0]         w_ncnt;
    logic [10:0]        w_nh;
    logic [10:0]        w_nv;

    assign w_w_in      = (stripe_w_in == 8'd0) ? 8'd1 : stripe_w_in;
    assign w_x0_in     = f_x0(centre_x_in, w_w_in);
    assign w_entry0    = f_entry(11'd0, centre_y_in, w_x0_in, w_w_in);
    assign w_entry_nxt = f_entry(r_v + 11'd1, r_cy, r_x0, r_w);
    assign w_row_on    = f_row_on(r_v, r_cy);

`ifdef MARKER_GEN_NOISE_EN
    logic [15:0] r_lfsr;
    logic        r_glitch_prev;
    logic        w_fb;

    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_glitch = (r_state == S_BAND) && (r_lfsr[7:0] == 8'h00)
                      && !r_glitch_prev;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_lfsr        <= 16'hACE1;
            r_glitch_prev <= 1'b0;
        end else if (r_busy && pixel_en_in &&
                     (r_state == S_BG_PRE || r_state == S_BAND ||
                      r_state == S_BG_POST)) begin
            r_lfsr        <= {r_lfsr[14:0], w_fb};
            r_glitch_prev <= w_glitch;
        end
    end
`else
    assign w_glitch = 1'b0;
`endif

    always_comb begin
        w_pix_rgb = BG_RGB;
        if (r_state == S_BAND)
            w_pix_rgb = (r_band[0] ^ w_glitch) ? WHITE_RGB : BLACK_RGB;
    end

    always_comb begin
        w_nstate = r_state;
        w_nband  = r_band;
        w_ncnt   = r_cnt;
        w_nh     = r_h + 11'd1;
        w_nv     = r_v;
        if (r_h == H_LAST) begin
            w_nh = 11'd0;
            if (r_v == V_LAST) begin
                w_nstate = S_DONE;
            end else begin
                w_nv = r_v + 11'd1;
                {w_nstate, w_nband, w_ncnt} = w_entry_nxt;
            end
        end else begin
            case (r_state)
                S_BG_PRE: begin
                    if (w_row_on &&
                        r_x0 == $signed({2'b00, r_h + 11'd1})) begin
                        w_nstate = S_BAND;
                        w_nband  = 4'd0;
                        w_ncnt   = {1'b0, r_w};
                    end
                end
                S_BAND: begin
                    if (r_cnt > 9'd1) begin
                        w_ncnt = r_cnt - 9'd1;
                    end else if (r_band == LAST_BAND) begin
                        w_nstate = S_BG_POST;
                    end else begin
                        w_nband = r_band + 4'd1;
                        w_ncnt  = (r_band + 4'd1 == CTR_BAND) ?
                                  {r_w, 1'b0} : {1'b0, r_w};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_band  <= 4'd0;
            r_cnt   <= 9'd0;
            r_h     <= 11'd0;
            r_v     <= 11'd0;
            r_cy    <= 11'd0;
            r_w     <= 8'd0;
            r_x0    <= 13'sd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_rgb   <= 3'd0;
            r_hcnt  <= 11'd0;
            r_vcnt  <= 11'd0;
            r_le    <= 1'b0;
            r_fe    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (start_in) begin
                        r_cy   <= centre_y_in;
                        r_w    <= w_w_in;
                        r_x0   <= w_x0_in;
                        r_busy <= 1'b1;
                        r_h    <= 11'd0;
                        r_v    <= 11'd0;
                        {r_state, r_band, r_cnt} <= w_entry0;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_COOL;
                end
                // One dead cycle after busy drops before a new start is taken.
                S_COOL: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= pixel_en_in;
                    if (pixel_en_in) begin
                        r_rgb   <= w_pix_rgb;
                        r_hcnt  <= r_h;
                        r_vcnt  <= r_v;
                        r_le    <= (r_h == H_LAST);
                        r_fe    <= (r_h == H_LAST) && (r_v == V_LAST);
                        r_state <= w_nstate;
                        r_band  <= w_nband;
                        r_cnt   <= w_ncnt;
                        r_h     <= w_nh;
                        r_v     <= w_nv;
                    end
                end
            endcase
        end
    end

    assign busy_out      = r_busy;
    assign valid_out     = r_valid;
    assign rgb_out       = r_rgb;
    assign hcount_out    = r_hcnt;
    assign vcount_out    = r_vcnt;
    assign line_end_out  = r_le;
    assign frame_end_out = r_fe;

endmodule

// File: tb/tb_marker_gen.sv
// Directed bench for marker_gen on a reduced 128x40 frame.
// Captures every valid pixel and checks it against a band-offset model.
module tb_marker_gen;

    localparam int H = 128;
    localparam int V = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pen = 1'b0;
    logic [10:0] cx = 11'd0;
    logic [10:0] cy = 11'd0;
    logic [7:0]  sw = 8'd0;
    logic        busy;
    logic        valid;
    logic [2:0]  rgb;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        le;
    logic        fe;

    marker_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .start_in     (start),
        .pixel_en_in  (pen),
        .centre_x_in  (cx),
        .centre_y_in  (cy),
        .stripe_w_in  (sw),
        .busy_out     (busy),
        .valid_out    (valid),
        .rgb_out      (rgb),
        .hcount_out   (hc),
        .vcount_out   (vc),
        .line_end_out (le),
        .frame_end_out(fe)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [2:0]  fb     [H*V];
    logic [2:0]  fb_ref [H*V];
    int          mh, mv, npix, nfe, ord_err, le_err, hold_err, fe_seen;
    int          m_cx, m_cy, m_w;
    logic [26:0] prev = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int m_rgb(int x, int y, int w, int h, int v);
        int wd, x0, off, b;
        wd = (w == 0) ? 1 : w;
        if (v < y - 16 || v > y + 15) return 2;
        x0  = x - 6 * wd;
        off = h - x0;
        if (off < 0 || off >= 11 * wd) return 2;
        if (off < 5 * wd)      b = off / wd;
        else if (off < 7 * wd) b = 5;
        else                   b = (off - 7 * wd) / wd + 6;
        return (b % 2 == 1) ? 7 : 0;
    endfunction

    task automatic clr_stats();
        mh = 0; mv = 0; npix = 0; nfe = 0;
        ord_err = 0; le_err = 0; hold_err = 0; fe_seen = 0;
        for (int i = 0; i < H * V; i++) fb[i] = 3'd5;
    endtask

    task automatic sample();
        logic [26:0] cur;
        cur = {rgb, hc, vc, le, fe};
        if (valid) begin
            if (hc != 11'(mh) || vc != 11'(mv)) ord_err++;
            if (int'(hc) < H && int'(vc) < V) fb[int'(vc) * H + int'(hc)] = rgb;
            npix++;
            if (le != (hc == 11'(H - 1))) le_err++;
            if (fe) begin
                nfe++;
                fe_seen = 1;
                if (hc != 11'(H - 1) || vc != 11'(V - 1)) ord_err++;
            end
            mh++;
            if (mh == H) begin mh = 0; mv++; end
        end else if (busy && cur != prev) begin
            hold_err++;
        end
        prev = cur;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic do_start(input int x, input int y, input int w);
        repeat (3) tick();
        cx = 11'(x); cy = 11'(y); sw = 8'(w);
        m_cx = x; m_cy = y; m_w = w;
        clr_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_set", 32'(busy), 1);
    endtask

    task automatic run_frame(input bit rnd);
        int c;
        c = 0;
        while (fe_seen == 0 && c < 4 * H * V) begin
            pen = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            c++;
        end
        pen = 1'b0;
        check("frame_timeout", fe_seen, 1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 10) begin tick(); c++; end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic frame_checks(input string tag);
        int bad;
        bad = 0;
        for (int v = 0; v < V; v++)
            for (int h = 0; h < H; h++)
                if (fb[v * H + h] !== 3'(m_rgb(m_cx, m_cy, m_w, h, v))) bad++;
        check({tag, "_model"}, bad, 0);
        check({tag, "_npix"}, npix, H * V);
        check({tag, "_order"}, ord_err, 0);
        check({tag, "_line_end"}, le_err, 0);
        check({tag, "_stall_hold"}, hold_err, 0);
        check({tag, "_frame_end_cnt"}, nfe, 1);
    endtask

    task automatic spot(input string tag, input int v, input int h,
                        input int exp);
        check(tag, 32'(fb[v * H + h]), exp);
    endtask

    initial begin
        int diff;
        tick();
        check("reset_outs", 32'({busy, valid, rgb, hc, vc, le, fe}), 0);
        rst_n = 1'b1;

        do_start(60, 20, 6);
        pen = 1'b1;
        repeat (300) tick();
        check("pre_reset_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outs", 32'({busy, valid, rgb, hc, vc, le, fe}), 0);
        tick();
        rst_n = 1'b1;
        pen = 1'b0;

        do_start(60, 20, 6);
        run_frame(1'b0);
        frame_checks("A");
        spot("A_r20c23", 20, 23, 2);
        spot("A_r20c24", 20, 24, 0);
        spot("A_r20c29", 20, 29, 0);
        spot("A_r20c30", 20, 30, 7);
        spot("A_r20c53", 20, 53, 0);
        spot("A_r20c54", 20, 54, 7);
        spot("A_r20c65", 20, 65, 7);
        spot("A_r20c66", 20, 66, 0);
        spot("A_r20c89", 20, 89, 7);
        spot("A_r20c90", 20, 90, 2);
        spot("A_r3c30", 3, 30, 2);
        spot("A_r4c30", 4, 30, 7);
        spot("A_r35c30", 35, 30, 7);
        spot("A_r36c30", 36, 30, 2);
        for (int i = 0; i < H * V; i++) fb_ref[i] = fb[i];

        tick();
        check("busy_drop", 32'(busy), 0);
        start = 1'b1;
        tick();
        check("start_ignored", 32'(busy), 0);
        tick();
        check("start_next", 32'(busy), 1);
        start = 1'b0;
        clr_stats();
        run_frame(1'b1);
        frame_checks("A_rand");
        diff = 0;
        for (int i = 0; i < H * V; i++) if (fb[i] !== fb_ref[i]) diff++;
        check("rand_vs_ref", diff, 0);
        wait_idle();

        do_start(20, 0, 8);
        pen = 1'b1;
        repeat (200) tick();
        cx = 11'd100; cy = 11'd30; sw = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(1'b0);
        frame_checks("B");
        spot("B_r0c0", 0, 0, 7);
        spot("B_r0c3", 0, 3, 7);
        spot("B_r0c4", 0, 4, 0);
        spot("B_r0c11", 0, 11, 0);
        spot("B_r0c12", 0, 12, 7);
        spot("B_r0c27", 0, 27, 7);
        spot("B_r0c28", 0, 28, 0);
        spot("B_r15c0", 15, 0, 7);
        spot("B_r16c0", 16, 0, 2);
        wait_idle();

        do_start(64, 39, 0);
        run_frame(1'b0);
        frame_checks("W0");
        spot("W0_r39c57", 39, 57, 2);
        spot("W0_r39c58", 39, 58, 0);
        spot("W0_r39c59", 39, 59, 7);
        spot("W0_r39c63", 39, 63, 7);
        spot("W0_r39c64", 39, 64, 7);
        spot("W0_r39c65", 39, 65, 0);
        spot("W0_r39c68", 39, 68, 7);
        spot("W0_r39c69", 39, 69, 2);
        spot("W0_r22c63", 22, 63, 2);
        spot("W0_r23c63", 23, 63, 7);
        wait_idle();

        do_start(120, 20, 6);
        run_frame(1'b0);
        frame_checks("C");
        spot("C_r20c0", 20, 0, 2);
        spot("C_r20c83", 20, 83, 2);
        spot("C_r20c84", 20, 84, 0);
        spot("C_r20c125", 20, 125, 7);
        spot("C_r20c126", 20, 126, 0);
        spot("C_r20c127", 20, 127, 0);
        spot("C_r21c0", 21, 0, 2);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
